// File: rtl/net_echo_responder.sv
// Store-and-forward loopback peer: buffers one packet, swaps the Ethernet MAC addresses and
// sends it back. Runt (1-flit) and oversize packets are dropped and counted.
module net_echo_responder #(
  parameter int unsigned MAX_FLITS = 190,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             net_out_valid,
  output logic             net_out_ready,
  input  logic [63:0]      net_out_bits_data,
  input  logic             net_out_bits_last,
  output logic             net_in_valid,
  input  logic             net_in_ready,
  output logic [63:0]      net_in_bits_data,
  output logic             net_in_bits_last,
  output logic [CNT_W-1:0] echo_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned      AddrW    = (MAX_FLITS > 2) ? $clog2(MAX_FLITS) : 1;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(MAX_FLITS - 1);

  typedef enum logic [1:0] {StRecv, StDrop, StSend} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0] last_idx_q, last_idx_d;
  logic [CNT_W-1:0] echo_q, echo_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [63:0]      mem_q [MAX_FLITS];

  logic        rx_ready, rx_fire, tx_valid, tx_fire;
  logic [47:0] dst_mac, src_mac;
  logic [63:0] tx_data;

  // Ready is held low during the reset cycle itself so nothing is accepted then.
  assign rx_ready = (state_q != StSend) && !reset;
  assign rx_fire  = net_out_valid && rx_ready;
  assign tx_valid = (state_q == StSend);
  assign tx_fire  = tx_valid && net_in_ready;

  assign dst_mac = mem_q[0][47:0];
  assign src_mac = {mem_q[1][31:0], mem_q[0][63:48]};

  always_comb begin
    tx_data = '0;
    if (tx_valid) begin
      if (rd_ptr_q == '0) begin
        tx_data = {dst_mac[15:0], src_mac};
      end else if (rd_ptr_q == AddrW'(1)) begin
        tx_data = {mem_q[1][63:32], dst_mac[47:16]};
      end else begin
        tx_data = mem_q[rd_ptr_q];
      end
    end
  end

  assign net_out_ready    = rx_ready;
  assign net_in_valid     = tx_valid;
  assign net_in_bits_data = tx_data;
  assign net_in_bits_last = tx_valid && (rd_ptr_q == last_idx_q);
  assign echo_count       = echo_q;
  assign drop_count       = drop_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_idx_d = last_idx_q;
    echo_d     = echo_q;
    drop_d     = drop_q;
    unique case (state_q)
      StRecv: begin
        if (rx_fire) begin
          if (net_out_bits_last) begin
            if (wr_ptr_q == '0) begin
              drop_d = drop_q + CNT_W'(1);
            end else begin
              last_idx_d = wr_ptr_q;
              rd_ptr_d   = '0;
              state_d    = StSend;
            end
          end else if (wr_ptr_q == LastAddr) begin
            state_d = StDrop;
          end else begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
          end
        end
      end
      StDrop: begin
        if (rx_fire && net_out_bits_last) begin
          drop_d   = drop_q + CNT_W'(1);
          wr_ptr_d = '0;
          state_d  = StRecv;
        end
      end
      StSend: begin
        if (tx_fire) begin
          if (rd_ptr_q == last_idx_q) begin
            echo_d   = echo_q + CNT_W'(1);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = StRecv;
          end else begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
          end
        end
      end
      default: state_d = StRecv;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StRecv;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_idx_q <= '0;
      echo_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_idx_q <= last_idx_d;
      echo_q     <= echo_d;
      drop_q     <= drop_d;
    end
  end

  // Packet storage needs no reset; only flits accepted in RECV are kept.
  always_ff @(posedge clock) begin
    if (rx_fire && (state_q == StRecv)) begin
      mem_q[wr_ptr_q] <= net_out_bits_data;
    end
  end

endmodule
